mdio_sched: RTL and testbench

//  Hardware Clause-22 MDIO master shared by NREQ requesters (MCU GPIO shim, link monitor, etc.).

---
 rtl/mdio_sched.sv | 202 ++++++++++++++++++++
 tb/tb_mdio_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_sched.sv
`default_nettype none
// ============================================================================
//  Module   : mdio_sched
//  Purpose  : Clause-22 MDIO master shared by NREQ requesters. Round-robin
//             arbitration, one 64-bit MDIO frame at a time on a single
//             MDC/MDIO pair, read data returned to the granted requester.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst            system clock, synchronous active-high reset
//    req_valid[NREQ]     request pending, held until req_ack
//    req_write[NREQ]     1 = write, 0 = read
//    req_phy/req_reg     5-bit PHY / register address per requester
//    req_wdata           16-bit write data per requester
//    req_ack[NREQ]       one-cycle pulse: request latched
//    rsp_valid[NREQ]     one-cycle pulse: transaction complete
//    rsp_rdata[16]       read data, valid with rsp_valid (0 for writes)
//    busy                high from grant through the rsp_valid cycle
//    mdc, mdio_o, mdio_t MDIO clock, data out, release (1 = high-Z)
//    mdio_i              MDIO pad input
// ============================================================================
module mdio_sched #(
    parameter int NREQ    = 3,
    parameter int CLK_DIV = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [5*NREQ-1:0]    req_phy,
    input  logic [5*NREQ-1:0]    req_reg,
    input  logic [16*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [15:0]          rsp_rdata,
    output logic                 busy,
    output logic                 mdc,
    output logic                 mdio_o,
    output logic                 mdio_t,
    input  logic                 mdio_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam logic [DW-1:0] C_DIV_MID = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] C_DIV_END = DW'(2 * CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [IW-1:0]      last_q;
    logic [NREQ-1:0]    sel_oh_q;
    logic               write_q;
    logic [63:0]        frame_q;
    logic [15:0]        rd_q;
    logic [DW-1:0]      div_q;
    logic [5:0]         bit_q;
    logic [NREQ-1:0]    req_ack_q;
    logic [NREQ-1:0]    rsp_valid_q;
    logic [15:0]        rsp_rdata_q;
    logic               busy_q;
    logic               mdc_q;
    logic               mdio_o_q;
    logic               mdio_t_q;

    // Arbitration and field selection for the candidate requester
    logic               found_d;
    logic [IW-1:0]      sel_d;
    logic [NREQ-1:0]    sel_oh_d;
    logic               write_d;
    logic [4:0]         phy_d;
    logic [4:0]         reg_d;
    logic [15:0]        wdata_d;
    logic [63:0]        frame_d;

    always_comb begin
        found_d  = 1'b0;
        sel_d    = '0;
        sel_oh_d = '0;
        write_d  = 1'b0;
        phy_d    = '0;
        reg_d    = '0;
        wdata_d  = '0;
        // Scan last+1, last+2, ... so the most recently served requester
        // is considered last.
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found_d && req_valid[i] && (i == (int'(last_q) + k) % NREQ)) begin
                    found_d = 1'b1;
                    sel_d   = IW'(i);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (sel_d == IW'(i)) begin
                sel_oh_d[i] = 1'b1;
                write_d     = req_write[i];
                phy_d       = req_phy[5*i +: 5];
                reg_d       = req_reg[5*i +: 5];
                wdata_d     = req_wdata[16*i +: 16];
            end
        end
        // Preamble, ST=01, OP, PHYAD, REGAD, TA, data; bit 0 sits at [63].
        // Read frames carry filler in TA/data; those bits are never driven.
        frame_d = {32'hFFFF_FFFF, 2'b01, (write_d ? 2'b01 : 2'b10), phy_d, reg_d,
                   (write_d ? 2'b10 : 2'b11), (write_d ? wdata_d : 16'h0000)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= IW'(NREQ - 1);
            sel_oh_q    <= '0;
            write_q     <= 1'b0;
            frame_q     <= '0;
            rd_q        <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            req_ack_q   <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            mdc_q       <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_t_q    <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        state_q   <= S_GRANT;
                        req_ack_q <= sel_oh_d;
                        sel_oh_q  <= sel_oh_d;
                        last_q    <= sel_d;
                        write_q   <= write_d;
                        frame_q   <= frame_d;
                        rd_q      <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                S_GRANT: begin
                    // This edge opens the mdc-low phase of bit 0.
                    state_q   <= S_SHIFT;
                    req_ack_q <= '0;
                    div_q     <= '0;
                    bit_q     <= '0;
                    mdc_q     <= 1'b0;
                    mdio_o_q  <= frame_q[63];
                    mdio_t_q  <= 1'b0;
                    frame_q   <= {frame_q[62:0], 1'b0};
                end
                S_SHIFT: begin
                    if (div_q == C_DIV_END) begin
                        div_q <= '0;
                        mdc_q <= 1'b0;
                        if (bit_q == 6'd63) begin
                            state_q     <= S_DONE;
                            mdio_o_q    <= 1'b1;
                            mdio_t_q    <= 1'b1;
                            rsp_valid_q <= sel_oh_q;
                            rsp_rdata_q <= write_q ? 16'h0000 : rd_q;
                        end else begin
                            bit_q    <= bit_q + 6'd1;
                            mdio_o_q <= frame_q[63];
                            frame_q  <= {frame_q[62:0], 1'b0};
                            // Reads release the line from bit 46 (TA) onward.
                            mdio_t_q <= !write_q && (bit_q >= 6'd45);
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                        if (div_q == C_DIV_MID) begin
                            mdc_q <= 1'b1;
                            if (!write_q && (bit_q >= 6'd48)) begin
                                rd_q <= {rd_q[14:0], mdio_i};
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= '0;
                    busy_q      <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ack   = req_ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign mdc       = mdc_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_t    = mdio_t_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdio_sched
//  Purpose  : Directed self-checking bench for mdio_sched (CLK_DIV=2 main
//             instance with a PHY model, CLK_DIV=25 instance for MDC timing).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mdio_sched;

    localparam int NREQ = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_write = '0;
    logic [5*NREQ-1:0]    req_phy   = '0;
    logic [5*NREQ-1:0]    req_reg   = '0;
    logic [16*NREQ-1:0]   req_wdata = '0;
    logic [NREQ-1:0]      req_ack;
    logic [NREQ-1:0]      rsp_valid;
    logic [15:0]          rsp_rdata;
    logic                 busy, mdc, mdio_o, mdio_t;
    logic                 mdio_i = 1'b1;

    logic [NREQ-1:0]      req_valid25 = '0;
    logic [NREQ-1:0]      req_ack25, rsp_valid25;
    logic [15:0]          rsp_rdata25;
    logic                 busy25, mdc25, mdio_o25, mdio_t25;
    logic                 mdio_i25 = 1'b1;

    int errs   = 0;
    int checks = 0;

    mdio_sched #(.NREQ(NREQ), .CLK_DIV(2)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .busy(busy), .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i)
    );

    mdio_sched #(.NREQ(NREQ), .CLK_DIV(25)) u_dut25 (
        .clk(clk), .rst(rst), .req_valid(req_valid25), .req_write(req_write),
        .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
        .req_ack(req_ack25), .rsp_valid(rsp_valid25), .rsp_rdata(rsp_rdata25),
        .busy(busy25), .mdc(mdc25), .mdio_o(mdio_o25), .mdio_t(mdio_t25), .mdio_i(mdio_i25)
    );

    always #5 clk = ~clk;

    // PHY model: counts bits from the ack, captures mdio_o/mdio_t on each
    // mdc rise (bit 0 stored at [63]) and returns phy_rdata on bits 48-63.
    logic [15:0] phy_rdata = 16'h0000;
    logic [63:0] cap_o = '0;
    logic [63:0] cap_t = '0;
    int          bitnum = 64;
    logic        mdc_prev = 1'b0;

    always @(negedge clk) begin
        if (req_ack != '0) begin
            bitnum   = 0;
            mdc_prev = 1'b0;
        end else begin
            if (mdc_prev && !mdc) bitnum = bitnum + 1;
            if (!mdc_prev && mdc && bitnum < 64) begin
                cap_o[63-bitnum] = mdio_o;
                cap_t[63-bitnum] = mdio_t;
            end
            mdc_prev = mdc;
        end
        mdio_i = (bitnum >= 48 && bitnum < 64) ? phy_rdata[63-bitnum] : 1'b1;
    end

    // Raise a request at a negedge, wait (bounded) for its ack, then drop it.
    task automatic issue(input int idx, input bit wr, input logic [4:0] phy,
                         input logic [4:0] rg, input logic [15:0] data, output int ack_cyc);
        req_write[idx]         = wr;
        req_phy[5*idx +: 5]    = phy;
        req_reg[5*idx +: 5]    = rg;
        req_wdata[16*idx +: 16] = data;
        req_valid[idx]         = 1'b1;
        ack_cyc = 0;
        do begin
            @(negedge clk);
            ack_cyc++;
        end while (req_ack == '0 && ack_cyc < 20);
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid == '0 && n < 5000);
    endtask

    task automatic test_reset;
        checks++; if (mdc !== 1'b0) begin errs++; $display("FAIL reset_mdc: got %b want 0", mdc); end
        checks++; if (mdio_o !== 1'b1) begin errs++; $display("FAIL reset_mdio_o: got %b want 1", mdio_o); end
        checks++; if (mdio_t !== 1'b1) begin errs++; $display("FAIL reset_mdio_t: got %b want 1", mdio_t); end
        checks++; if (req_ack !== 3'b000) begin errs++; $display("FAIL reset_ack: got %b want 000", req_ack); end
        checks++; if (rsp_valid !== 3'b000) begin errs++; $display("FAIL reset_rsp_valid: got %b want 000", rsp_valid); end
        checks++; if (rsp_rdata !== 16'h0000) begin errs++; $display("FAIL reset_rdata: got %h want 0000", rsp_rdata); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_write;
        int ac, n;
        issue(0, 1'b1, 5'd16, 5'd8, 16'h1140, ac);
        checks++; if (ac !== 1) begin errs++; $display("FAIL wr_ack_latency: got %0d want 1", ac); end
        checks++; if (req_ack !== 3'b001) begin errs++; $display("FAIL wr_ack: got %b want 001", req_ack); end
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL wr_busy_grant: got %b want 1", busy); end
        wait_rsp(n);
        checks++; if (n !== 257) begin errs++; $display("FAIL wr_rsp_latency: got %0d want 257", n); end
        checks++; if (rsp_valid !== 3'b001) begin errs++; $display("FAIL wr_rsp_valid: got %b want 001", rsp_valid); end
        checks++; if (rsp_rdata !== 16'h0000) begin errs++; $display("FAIL wr_rdata: got %h want 0000", rsp_rdata); end
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL wr_busy_done: got %b want 1", busy); end
        checks++; if (cap_o !== 64'hFFFF_FFFF_5822_1140) begin errs++; $display("FAIL wr_frame: got %h want ffffffff58221140", cap_o); end
        checks++; if (cap_t !== 64'h0) begin errs++; $display("FAIL wr_mdio_t: got %h want 0", cap_t); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL wr_busy_after: got %b want 0", busy); end
        checks++; if (rsp_valid !== 3'b000) begin errs++; $display("FAIL wr_rsp_pulse: got %b want 000", rsp_valid); end
    endtask

    task automatic test_read;
        int ac, n;
        phy_rdata = 16'h0141;
        issue(1, 1'b0, 5'd3, 5'd2, 16'h0000, ac);
        checks++; if (req_ack !== 3'b010) begin errs++; $display("FAIL rd_ack: got %b want 010", req_ack); end
        wait_rsp(n);
        checks++; if (n !== 257) begin errs++; $display("FAIL rd_rsp_latency: got %0d want 257", n); end
        checks++; if (rsp_valid !== 3'b010) begin errs++; $display("FAIL rd_rsp_valid: got %b want 010", rsp_valid); end
        checks++; if (rsp_rdata !== 16'h0141) begin errs++; $display("FAIL rd_rdata: got %h want 0141", rsp_rdata); end
        // Bits 0-45: preamble, ST=01, OP=10, PHYAD=00011, REGAD=00010.
        checks++; if (cap_o[63:18] !== {32'hFFFF_FFFF, 14'b01_10_00011_00010}) begin
            errs++; $display("FAIL rd_header: got %h want %h", cap_o[63:18], {32'hFFFF_FFFF, 14'b01_10_00011_00010}); end
        checks++; if (cap_t !== 64'h0000_0000_0003_FFFF) begin errs++; $display("FAIL rd_mdio_t: got %h want 000000000003ffff", cap_t); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int ac, n, w, rsp_cnt;
        issue(0, 1'b0, 5'd3, 5'd2, 16'h0000, ac);
        w = 0;
        while (bitnum != 40 && w < 1000) begin @(negedge clk); w++; end
        checks++; if (w >= 1000) begin errs++; $display("FAIL abort_reach_bit40: got timeout want bit 40"); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mdc !== 1'b0) begin errs++; $display("FAIL abort_mdc: got %b want 0", mdc); end
        checks++; if (mdio_t !== 1'b1) begin errs++; $display("FAIL abort_mdio_t: got %b want 1", mdio_t); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_busy: got %b want 0", busy); end
        rst = 1'b0;
        rsp_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) rsp_cnt++;
        end
        checks++; if (rsp_cnt !== 0) begin errs++; $display("FAIL abort_no_rsp: got %0d want 0", rsp_cnt); end
        issue(2, 1'b1, 5'd2, 5'd1, 16'hBEEF, ac);
        checks++; if (req_ack !== 3'b100) begin errs++; $display("FAIL abort_new_ack: got %b want 100", req_ack); end
        wait_rsp(n);
        checks++; if (n !== 257) begin errs++; $display("FAIL abort_new_latency: got %0d want 257", n); end
        checks++; if (rsp_valid !== 3'b100) begin errs++; $display("FAIL abort_new_rsp: got %b want 100", rsp_valid); end
        checks++; if (cap_o !== 64'hFFFF_FFFF_5106_BEEF) begin errs++; $display("FAIL abort_new_frame: got %h want ffffffff5106beef", cap_o); end
        @(negedge clk);
    endtask

    task automatic test_ignored_pulse;
        int ac, ack1, rsp0, rsp1;
        issue(0, 1'b1, 5'd1, 5'd0, 16'h1140, ac);
        repeat (20) @(negedge clk);
        req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        ack1 = 0; rsp0 = 0; rsp1 = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (req_ack != '0) ack1++;
            if (rsp_valid[0]) rsp0++;
            if (rsp_valid[1]) rsp1++;
        end
        checks++; if (ack1 !== 0) begin errs++; $display("FAIL pulse_no_ack: got %0d want 0", ack1); end
        checks++; if (rsp0 !== 1) begin errs++; $display("FAIL pulse_rsp0: got %0d want 1", rsp0); end
        checks++; if (rsp1 !== 0) begin errs++; $display("FAIL pulse_no_rsp1: got %0d want 0", rsp1); end
    endtask

    task automatic test_round_robin;
        int acks, rsps, cyc;
        logic [2:0] exp_ack;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_write = 3'b111;
        req_valid = 3'b111;
        acks = 0; rsps = 0; cyc = 0;
        while (acks < 6 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid != '0) rsps++;
            if (req_ack != '0) begin
                exp_ack = 3'b001 << (acks % 3);
                checks++; if (req_ack !== exp_ack) begin errs++; $display("FAIL rr_order%0d: got %b want %b", acks, req_ack, exp_ack); end
                checks++; if (rsps !== acks) begin errs++; $display("FAIL rr_serial%0d: got %0d rsps want %0d", acks, rsps, acks); end
                acks++;
            end
        end
        req_valid = 3'b000;
        checks++; if (acks !== 6) begin errs++; $display("FAIL rr_ack_count: got %0d want 6", acks); end
        cyc = 0;
        while (busy && cyc < 1000) begin @(negedge clk); cyc++; end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rr_drain: got busy=%b want 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_clkdiv25;
        int n, run, highs, bad_len, bad_edge;
        logic pm, po;
        bit seen_high;
        req_write[0] = 1'b1;
        req_phy[4:0] = 5'd5;
        req_reg[4:0] = 5'd9;
        req_wdata[15:0] = 16'hA5A5;
        req_valid25[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (req_ack25 == '0 && n < 20);
        req_valid25[0] = 1'b0;
        checks++; if (req_ack25 !== 3'b001) begin errs++; $display("FAIL cd25_ack: got %b want 001", req_ack25); end
        n = 0; run = 0; highs = 0; bad_len = 0; bad_edge = 0; seen_high = 0;
        pm = mdc25; po = mdio_o25;
        do begin
            @(negedge clk);
            n++;
            if (mdc25 != pm) begin
                if (pm) begin highs++; seen_high = 1; if (run != 25) bad_len++; end
                else if (seen_high && run != 25) bad_len++;
                run = 1;
            end else begin
                run++;
            end
            if (n > 1 && mdio_o25 != po && !(pm && !mdc25)) bad_edge++;
            pm = mdc25; po = mdio_o25;
        end while (rsp_valid25 == '0 && n < 4000);
        checks++; if (n !== 3201) begin errs++; $display("FAIL cd25_latency: got %0d want 3201", n); end
        checks++; if (highs !== 64) begin errs++; $display("FAIL cd25_mdc_pulses: got %0d want 64", highs); end
        checks++; if (bad_len !== 0) begin errs++; $display("FAIL cd25_phase_len: got %0d bad want 0", bad_len); end
        checks++; if (bad_edge !== 0) begin errs++; $display("FAIL cd25_mdio_edge: got %0d bad want 0", bad_edge); end
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_reset_abort();
        test_ignored_pulse();
        test_round_robin();
        test_clkdiv25();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
